// File: rtl/axilite_gpio_in_if.sv
// AXI4-Lite bus bundle for axilite_gpio_in.
// Carries the AW, W, B, AR and R channels.
// The master modport drives requests, and the slave modport drives responses.
interface axilite_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  awvalid;
   logic                  awready;
   logic [31:0]           wdata;
   logic [3:0]            wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;
   logic [31:0]           rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axilite_gpio_in.sv
// AXI4-Lite responder for input GPIOs.
// The block synchronises the pins and exposes their live value.
// It captures enabled rising and falling edges into a sticky W1C STATUS register.
// It raises irq_o while any STATUS bit is set.
//
// Ports:
//   clock_i, reset_ni : clock and asynchronous active-low reset
//   s_axilite         : AXI4-Lite slave (axilite_if.slave); only addr[4:2] is decoded
//   gpio_in_i         : asynchronous input pins
//   irq_o             : level interrupt, |STATUS
//
// Map: 0x00 DATA, 0x04 RISE_EN, 0x08 FALL_EN, 0x0C STATUS (W1C), 0x10 RAW_EDGE.
//      0x14-0x1C respond SLVERR.
module axilite_gpio_in #(
   parameter int NUM_GPIO   = 16,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                clock_i,
   input  logic                reset_ni,
   axilite_if.slave            s_axilite,
   input  logic [NUM_GPIO-1:0] gpio_in_i,
   output logic                irq_o
);

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
   typedef enum logic       {R_IDLE, R_RESP} rd_state_t;

   logic [NUM_GPIO-1:0] sync1, sync2, prev, rise, fall;
   logic [NUM_GPIO-1:0] rise_en, fall_en, status, status_nxt, clr, wmask, wval;

   // ---------------- input path ----------------
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= gpio_in_i;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign rise = sync2 & ~prev;
   assign fall = ~sync2 & prev;

   // ---------------- write channel ----------------
   wr_state_t   wr_state, wr_state_nxt;
   logic [2:0]  aw_idx_q, wr_idx;
   logic [31:0] wdata_q, wr_data, wr_mask32;
   logic [3:0]  wstrb_q, wr_strb;
   logic [1:0]  bresp_q;
   logic        aw_hs, w_hs, commit;

   assign s_axilite.awready = (wr_state == W_IDLE) || (wr_state == W_HAVE_W);
   assign s_axilite.wready  = (wr_state == W_IDLE) || (wr_state == W_HAVE_AW);
   assign s_axilite.bvalid  = (wr_state == W_RESP);
   assign s_axilite.bresp   = bresp_q;

   assign aw_hs  = s_axilite.awvalid && s_axilite.awready;
   assign w_hs   = s_axilite.wvalid && s_axilite.wready;
   // Commit on the edge that completes the AW/W pair, whichever order they came in.
   assign commit = (aw_hs && w_hs) ||
                   (aw_hs && wr_state == W_HAVE_W) ||
                   (w_hs  && wr_state == W_HAVE_AW);

   // An earlier-accepted channel is served from its holding register.
   assign wr_idx  = (wr_state == W_HAVE_AW) ? aw_idx_q : s_axilite.awaddr[4:2];
   assign wr_data = (wr_state == W_HAVE_W) ? wdata_q : s_axilite.wdata;
   assign wr_strb = (wr_state == W_HAVE_W) ? wstrb_q : s_axilite.wstrb;

   assign wr_mask32 = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
   assign wmask     = wr_mask32[NUM_GPIO-1:0];
   assign wval      = wr_data[NUM_GPIO-1:0] & wmask;

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) wr_state <= W_IDLE;
      else           wr_state <= wr_state_nxt;
   end

   always_comb begin
      wr_state_nxt = wr_state;
      case (wr_state)
         W_IDLE:    if (commit) wr_state_nxt = W_RESP;
                    else if (aw_hs) wr_state_nxt = W_HAVE_AW;
                    else if (w_hs)  wr_state_nxt = W_HAVE_W;
         W_HAVE_AW: if (commit) wr_state_nxt = W_RESP;
         W_HAVE_W:  if (commit) wr_state_nxt = W_RESP;
         W_RESP:    if (s_axilite.bready) wr_state_nxt = W_IDLE;
         default:   wr_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         aw_idx_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bresp_q  <= 2'b00;
         rise_en  <= '0;
         fall_en  <= '0;
      end else begin
         if (aw_hs) aw_idx_q <= s_axilite.awaddr[4:2];
         if (w_hs) begin
            wdata_q <= s_axilite.wdata;
            wstrb_q <= s_axilite.wstrb;
         end
         if (commit) begin
            bresp_q <= (wr_idx > 3'd4) ? 2'b10 : 2'b00;
            if (wr_idx == 3'd1) rise_en <= (rise_en & ~wmask) | wval;
            if (wr_idx == 3'd2) fall_en <= (fall_en & ~wmask) | wval;
         end
      end
   end

   // Captured edges are ORed in after the clear, so a same-edge set survives a W1C.
   assign clr        = (commit && wr_idx == 3'd3) ? wval : '0;
   assign status_nxt = (status & ~clr) | (rise & rise_en) | (fall & fall_en);

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) status <= '0;
      else           status <= status_nxt;
   end

   assign irq_o = |status;

   // ---------------- read channel ----------------
   rd_state_t   rd_state, rd_state_nxt;
   logic [2:0]  rd_idx;
   logic [31:0] rd_val, rdata_q;
   logic [1:0]  rresp_q;
   logic        ar_hs;

   assign s_axilite.arready = (rd_state == R_IDLE);
   assign s_axilite.rvalid  = (rd_state == R_RESP);
   assign s_axilite.rdata   = rdata_q;
   assign s_axilite.rresp   = rresp_q;
   assign ar_hs             = s_axilite.arvalid && s_axilite.arready;
   assign rd_idx            = s_axilite.araddr[4:2];

   always_comb begin
      rd_val = '0;
      case (rd_idx)
         3'd0:    rd_val = 32'(sync2);
         3'd1:    rd_val = 32'(rise_en);
         3'd2:    rd_val = 32'(fall_en);
         3'd3:    rd_val = 32'(status);
         3'd4:    rd_val = 32'(rise | fall);
         default: rd_val = '0;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) rd_state <= R_IDLE;
      else           rd_state <= rd_state_nxt;
   end

   always_comb begin
      rd_state_nxt = rd_state;
      case (rd_state)
         R_IDLE:  if (ar_hs) rd_state_nxt = R_RESP;
         R_RESP:  if (s_axilite.rready) rd_state_nxt = R_IDLE;
         default: rd_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         rdata_q <= '0;
         rresp_q <= 2'b00;
      end else if (ar_hs) begin
         rdata_q <= rd_val;
         rresp_q <= (rd_idx > 3'd4) ? 2'b10 : 2'b00;
      end
   end

   // Address bits above [4:2] and data/strobe bits beyond NUM_GPIO are intentionally ignored.
   logic unused_bits;
   assign unused_bits = ^{s_axilite.awaddr[ADDR_WIDTH-1:0], s_axilite.araddr[ADDR_WIDTH-1:0],
                          wr_data, wr_mask32};

endmodule

// File: tb/tb_axilite_gpio_in.sv
module tb_axilite_gpio_in;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] gpio = '0;
   logic        irq;

   axilite_if #(.ADDR_WIDTH(32)) bus ();

   axilite_gpio_in #(.NUM_GPIO(16), .ADDR_WIDTH(32)) dut (
      .clock_i   (clk),
      .reset_ni  (rst_n),
      .s_axilite (bus),
      .gpio_in_i (gpio),
      .irq_o     (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      string       name;
   } txn_t;

   txn_t exp_q[$];
   txn_t obs_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   stall_cycles, stall_viol;

   task automatic expect_txn(input string n, input logic [31:0] d, input logic [1:0] r);
      txn_t e;
      e.data = d; e.resp = r; e.name = n;
      exp_q.push_back(e);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Read: arvalid from the first cycle, rready held high; response pushed to obs_q.
   task automatic axi_read(input logic [31:0] a);
      txn_t o;
      bit   got = 0, ar_done = 0;
      bus.araddr = a;
      bus.rready = 1'b1;
      for (int c = 0; c < 40 && !got; c++) begin
         bus.arvalid = !ar_done;
         @(negedge clk);
         if (bus.arvalid && bus.arready) ar_done = 1;
         if (bus.rvalid) begin
            o.data = bus.rdata; o.resp = bus.rresp; o.name = "";
            obs_q.push_back(o);
            got = 1;
         end
         @(posedge clk); #1;
      end
      bus.arvalid = 1'b0;
      bus.rready  = 1'b0;
      if (!got) $display("FAIL read_timeout addr=%h: no R response in 40 cycles", a);
   endtask

   // Write with independent AW/W start delays and a bready hold-off counted in bvalid cycles.
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly);
      txn_t o;
      bit   got = 0, aw_done = 0, w_done = 0, aw_hs, w_hs;
      bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
      stall_cycles = 0; stall_viol = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         bus.awvalid = !aw_done && (c >= aw_dly);
         bus.wvalid  = !w_done && (c >= w_dly);
         bus.bready  = (stall_cycles >= b_dly);
         @(negedge clk);
         aw_hs = bus.awvalid && bus.awready;
         w_hs  = bus.wvalid && bus.wready;
         if (bus.bvalid) begin
            if (bus.awready || bus.wready) stall_viol++;
            if (bus.bready) begin
               o.data = '0; o.resp = bus.bresp; o.name = "";
               obs_q.push_back(o);
               got = 1;
            end else stall_cycles++;
         end
         @(posedge clk); #1;
         aw_done = aw_done || aw_hs;
         w_done  = w_done || w_hs;
      end
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      if (!got) $display("FAIL write_timeout addr=%h: no B response in 40 cycles", a);
   endtask

   task automatic test_reset();
      txn_t e, o;
      bus.awaddr = 32'h4; bus.awvalid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({bus.bvalid, bus.rvalid, bus.rdata, bus.bresp, bus.rresp, irq} !== 38'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: bvalid=%b rvalid=%b rdata=%h bresp=%b rresp=%b irq=%b, required all 0",
                  bus.bvalid, bus.rvalid, bus.rdata, bus.bresp, bus.rresp, irq);
      end
      @(posedge clk); #1;
      bus.awvalid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
         miscompares++;
         $display("FAIL reset_ready: aw/w/ar ready=%b, required 111", {bus.awready, bus.wready, bus.arready});
      end
      @(posedge clk); #1;
      expect_txn("reset_status", 32'h0, 2'b00); axi_read(32'hC);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin
            miscompares++; $display("FAIL %s: no response, required data=%h resp=%b", e.name, e.data, e.resp);
         end else begin
            o = obs_q.pop_front();
            if (o.data !== e.data || o.resp !== e.resp) begin
               miscompares++;
               $display("FAIL %s: got data=%h resp=%b, required data=%h resp=%b", e.name, o.data, o.resp, e.data, e.resp);
            end
         end
      end
   endtask

   task automatic test_input_sync();
      txn_t e, o;
      gpio = 16'hA5A5;
      // This AR handshakes on the next edge, while the pin value is still only in sync1.
      expect_txn("data_early", 32'h0, 2'b00);    axi_read(32'h0);
      expect_txn("data_sync", 32'hA5A5, 2'b00);  axi_read(32'h0);
      cycles(3);
      expect_txn("sync_status", 32'h0, 2'b00);   axi_read(32'hC);
      @(negedge clk);
      vectors++;
      if (irq !== 1'b0) begin miscompares++; $display("FAIL sync_irq: irq=%b, required 0", irq); end
      @(posedge clk); #1;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin
            miscompares++; $display("FAIL %s: no response, required data=%h resp=%b", e.name, e.data, e.resp);
         end else begin
            o = obs_q.pop_front();
            if (o.data !== e.data || o.resp !== e.resp) begin
               miscompares++;
               $display("FAIL %s: got data=%h resp=%b, required data=%h resp=%b", e.name, o.data, o.resp, e.data, e.resp);
            end
         end
      end
   endtask

   task automatic test_edge_capture();
      txn_t e, o;
      gpio = 16'h0000; cycles(4);
      expect_txn("wr_rise_en", 32'h0, 2'b00); axi_write(32'h4, 32'h1, 4'hF, 0, 0, 0);
      expect_txn("wr_fall_en", 32'h0, 2'b00); axi_write(32'h8, 32'h2, 4'hF, 0, 0, 0);
      gpio = 16'h0003; cycles(4);
      gpio = 16'h0000; cycles(4);
      @(negedge clk);
      vectors++;
      if (irq !== 1'b1) begin miscompares++; $display("FAIL edge_irq_set: irq=%b, required 1", irq); end
      @(posedge clk); #1;
      expect_txn("edge_status", 32'h3, 2'b00);  axi_read(32'hC);
      expect_txn("w1c_bit0", 32'h0, 2'b00);     axi_write(32'hC, 32'h1, 4'hF, 0, 0, 0);
      expect_txn("status_after1", 32'h2, 2'b00); axi_read(32'hC);
      expect_txn("w1c_bit1", 32'h0, 2'b00);     axi_write(32'hC, 32'h2, 4'hF, 0, 0, 0);
      @(negedge clk);
      vectors++;
      if (irq !== 1'b0) begin miscompares++; $display("FAIL edge_irq_clear: irq=%b, required 0", irq); end
      @(posedge clk); #1;
      expect_txn("status_cleared", 32'h0, 2'b00); axi_read(32'hC);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin
            miscompares++; $display("FAIL %s: no response, required data=%h resp=%b", e.name, e.data, e.resp);
         end else begin
            o = obs_q.pop_front();
            if (o.data !== e.data || o.resp !== e.resp) begin
               miscompares++;
               $display("FAIL %s: got data=%h resp=%b, required data=%h resp=%b", e.name, o.data, o.resp, e.data, e.resp);
            end
         end
      end
   endtask

   task automatic test_race();
      txn_t e, o;
      gpio = 16'h0001; cycles(4);
      gpio = 16'h0000; cycles(4);
      expect_txn("race_pre", 32'h1, 2'b00); axi_read(32'hC);
      // The pin rises after edge E0, and rise is high in the cycle ending at E3.
      // The write below commits on E3.
      gpio = 16'h0001; cycles(2);
      expect_txn("race_w1c", 32'h0, 2'b00);   axi_write(32'hC, 32'h1, 4'hF, 0, 0, 0);
      expect_txn("race_status", 32'h1, 2'b00); axi_read(32'hC);
      expect_txn("race_w1c2", 32'h0, 2'b00);  axi_write(32'hC, 32'h1, 4'hF, 0, 0, 0);
      expect_txn("race_clear", 32'h0, 2'b00); axi_read(32'hC);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin
            miscompares++; $display("FAIL %s: no response, required data=%h resp=%b", e.name, e.data, e.resp);
         end else begin
            o = obs_q.pop_front();
            if (o.data !== e.data || o.resp !== e.resp) begin
               miscompares++;
               $display("FAIL %s: got data=%h resp=%b, required data=%h resp=%b", e.name, o.data, o.resp, e.data, e.resp);
            end
         end
      end
   endtask

   task automatic test_handshake();
      txn_t e, o;
      // W leads AW by 3 cycles; bready is held off for 5 bvalid cycles.
      expect_txn("w_first", 32'h0, 2'b00); axi_write(32'h4, 32'h0000FFFF, 4'b0001, 3, 0, 5);
      vectors++;
      if (stall_cycles != 5 || stall_viol != 0) begin
         miscompares++;
         $display("FAIL b_stall: bvalid-held cycles=%0d ready-while-bvalid=%0d, required 5 and 0", stall_cycles, stall_viol);
      end
      expect_txn("rise_en_strb", 32'h00FF, 2'b00); axi_read(32'h4);
      // AW leads W by 2 cycles; two lanes enabled.
      expect_txn("aw_first", 32'h0, 2'b00); axi_write(32'h8, 32'hFFFF8002, 4'b0011, 0, 2, 0);
      expect_txn("fall_en_rd", 32'h8002, 2'b00); axi_read(32'h8);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin
            miscompares++; $display("FAIL %s: no response, required data=%h resp=%b", e.name, e.data, e.resp);
         end else begin
            o = obs_q.pop_front();
            if (o.data !== e.data || o.resp !== e.resp) begin
               miscompares++;
               $display("FAIL %s: got data=%h resp=%b, required data=%h resp=%b", e.name, o.data, o.resp, e.data, e.resp);
            end
         end
      end
   endtask

   task automatic test_decode();
      txn_t e, o;
      expect_txn("wr_unmapped", 32'h0, 2'b10);     axi_write(32'h18, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      expect_txn("rise_en_kept", 32'h00FF, 2'b00); axi_read(32'h4);
      expect_txn("fall_en_kept", 32'h8002, 2'b00); axi_read(32'h8);
      expect_txn("status_kept", 32'h0, 2'b00);     axi_read(32'hC);
      expect_txn("rd_1c", 32'h0, 2'b10);           axi_read(32'h1C);
      expect_txn("rd_14", 32'h0, 2'b10);           axi_read(32'h14);
      expect_txn("wr_data_reg", 32'h0, 2'b00);     axi_write(32'h0, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      expect_txn("data_unaffected", 32'h1, 2'b00); axi_read(32'h0);
      expect_txn("raw_edge_idle", 32'h0, 2'b00);   axi_read(32'h10);
      expect_txn("addr_lsb_ignored", 32'h00FF, 2'b00); axi_read(32'h7);
      expect_txn("wr_upper_bits", 32'h0, 2'b00);   axi_write(32'h4, 32'hFFFF0F0F, 4'hF, 0, 0, 0);
      expect_txn("upper_bits_zero", 32'h0F0F, 2'b00); axi_read(32'h4);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin
            miscompares++; $display("FAIL %s: no response, required data=%h resp=%b", e.name, e.data, e.resp);
         end else begin
            o = obs_q.pop_front();
            if (o.data !== e.data || o.resp !== e.resp) begin
               miscompares++;
               $display("FAIL %s: got data=%h resp=%b, required data=%h resp=%b", e.name, o.data, o.resp, e.data, e.resp);
            end
         end
      end
   endtask

   initial begin
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
      bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      test_reset();
      test_input_sync();
      test_edge_capture();
      test_race();
      test_handshake();
      test_decode();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
